// File: rtl/ram_arb_pkg.sv
// Shared defaults and types for the two-master RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef logic master_id_t;

  // One in-flight read: issued last cycle, data arrives on ram_dout this cycle
  typedef struct packed {
    logic       vld;
    master_id_t id;
  } rd_slot_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; the pointer names the master favoured on a tie.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  master_id_t prio_q;
  master_id_t prio_d;

  // Grant is combinational and forced low while reset is high
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (!reset) begin
      if (req[0] && req[1]) begin
        gnt = prio_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
      if (gnt[0]) begin
        prio_d = 1'b1;
      end else if (gnt[1]) begin
        prio_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two masters onto one synchronous single-port RAM and routes read
// data back to the issuing master two cycles after the grant.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_din,
  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_din,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m0_dout,
  output logic [DATA_W-1:0] m1_dout,
  output logic              m0_valid,
  output logic              m1_valid,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [1:0] gnt;
  rd_slot_t   slot_q;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   ({m1_req, m0_req}),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Winner's command onto the RAM bus; all zero when nobody is granted
  always_comb begin
    ram_cen  = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt[0]) begin
      ram_cen  = 1'b1;
      ram_wen  = m0_wen;
      ram_addr = m0_addr;
      ram_din  = m0_din;
    end else if (gnt[1]) begin
      ram_cen  = 1'b1;
      ram_wen  = m1_wen;
      ram_addr = m1_addr;
      ram_din  = m1_din;
    end
  end

  // Read-return pipeline: slot tags the issuing master, dout/valid is the second stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q   <= '0;
      m0_dout  <= '0;
      m1_dout  <= '0;
      m0_valid <= 1'b0;
      m1_valid <= 1'b0;
    end else begin
      slot_q.vld <= ram_cen & ~ram_wen;
      slot_q.id  <= master_id_t'(gnt[1]);
      m0_valid   <= slot_q.vld & ~slot_q.id;
      m1_valid   <= slot_q.vld &  slot_q.id;
      if (slot_q.vld && !slot_q.id) begin
        m0_dout <= ram_dout;
      end
      if (slot_q.vld && slot_q.id) begin
        m1_dout <= ram_dout;
      end
    end
  end

endmodule
